// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a word-addressed data memory. Stores are visible on the
// memory port from the cycle after acceptance; St_Ready drops at DEPTH entries, with no bypass.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 11
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic                         St_Valid,
   output logic                         St_Ready,
   input  logic [31:0]                  St_Addr,
   input  logic [31:0]                  St_Data,
   input  logic [1:0]                   St_Size,
   output logic                         St_Err,
   input  logic                         Ld_Req,
   input  logic [31:0]                  Ld_Addr,
   output logic                         Ld_Hazard,
   output logic [AW-1:0]                Mem_A,
   output logic [31:0]                  Mem_Din,
   output logic [3:0]                   Mem_BE,
   output logic                         Mem_WE,
   output logic                         Empty,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   dat;
      logic [3:0]    be;
   } entry_t;

   entry_t           ent_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   logic             st_acc;
   logic             st_push;
   logic             lane_err;
   logic [3:0]       lane_be;
   logic [31:0]      lane_dat;
   logic             hit;
   logic             drain_en;
   entry_t           head;
   logic [AW-1:0]    ld_wa;

   logic             unused_addr_bits;
   assign unused_addr_bits = ^{St_Addr[31:AW+2], Ld_Addr[31:AW+2], Ld_Addr[1:0]};

   assign ld_wa    = Ld_Addr[AW+1:2];
   assign Empty    = (count_q == '0);
   assign St_Ready = (count_q != CW'(DEPTH));
   assign Count    = count_q;
   assign st_acc   = St_Valid && St_Ready;
   assign st_push  = st_acc && !lane_err;

   // Replicate the datum across every lane it could land in; the byte enables select the lane.
   always_comb begin
      lane_be  = 4'b0000;
      lane_dat = 32'h0;
      lane_err = 1'b0;
      case (St_Size)
         2'b00: begin
            lane_be  = 4'b0001 << St_Addr[1:0];
            lane_dat = {4{St_Data[7:0]}};
         end
         2'b01: begin
            lane_be  = St_Addr[1] ? 4'b1100 : 4'b0011;
            lane_dat = {2{St_Data[15:0]}};
            lane_err = St_Addr[0];
         end
         2'b10: begin
            lane_be  = 4'b1111;
            lane_dat = St_Data;
            lane_err = |St_Addr[1:0];
         end
         default: lane_err = 1'b1;
      endcase
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (ent_q[i].addr == ld_wa)) hit = 1'b1;
      end
   end

   // A hazarding load yields the port so the matching store can retire first.
   assign Ld_Hazard = Ld_Req && hit;
   assign drain_en  = !Empty && (!Ld_Req || Ld_Hazard);
   assign head      = ent_q[rd_ptr];

   always_comb begin
      Mem_WE  = drain_en;
      Mem_A   = ld_wa;
      Mem_Din = 32'h0;
      Mem_BE  = 4'b0000;
      if (drain_en) begin
         Mem_A   = head.addr;
         Mem_Din = head.dat;
         Mem_BE  = head.be;
      end
   end

   always_ff @(posedge Clk) begin
      if (st_push) begin
         ent_q[wr_ptr] <= '{addr: St_Addr[AW+1:2], dat: lane_dat, be: lane_be};
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         St_Err  <= 1'b0;
      end else begin
         St_Err <= st_acc && lane_err;
         if (drain_en) begin
            vld_q[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (st_push) begin
            vld_q[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         case ({st_push, drain_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 11;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          St_Valid;
   logic          St_Ready;
   logic [31:0]   St_Addr;
   logic [31:0]   St_Data;
   logic [1:0]    St_Size;
   logic          St_Err;
   logic          Ld_Req;
   logic [31:0]   Ld_Addr;
   logic          Ld_Hazard;
   logic [AW-1:0] Mem_A;
   logic [31:0]   Mem_Din;
   logic [3:0]    Mem_BE;
   logic          Mem_WE;
   logic          Empty;
   logic [2:0]    Count;

   always #5 Clk = ~Clk;

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .St_Valid(St_Valid), .St_Ready(St_Ready), .St_Addr(St_Addr), .St_Data(St_Data),
      .St_Size(St_Size), .St_Err(St_Err),
      .Ld_Req(Ld_Req), .Ld_Addr(Ld_Addr), .Ld_Hazard(Ld_Hazard),
      .Mem_A(Mem_A), .Mem_Din(Mem_Din), .Mem_BE(Mem_BE), .Mem_WE(Mem_WE),
      .Empty(Empty), .Count(Count)
   );

   typedef struct {
      logic [AW-1:0] wa;
      logic [31:0]   d;
      logic [3:0]    be;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic exp_err;
   logic m_acc, m_drain, m_push, m_bad;
   ent_t m_new;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [1:0] sz, input logic lr, input logic [31:0] la);
      @(negedge Clk);
      St_Valid = v; St_Addr = sa; St_Data = sd; St_Size = sz; Ld_Req = lr; Ld_Addr = la;
      #1;
   endtask

   // Reference: a store of nb bytes at offset a must have a divisible by nb; its bytes land at
   // lanes a..a+nb-1, and every lane carries byte (lane mod nb) of the datum.
   task automatic model_check();
      int n, nb, a;
      logic hz;
      logic [AW-1:0] ea;
      logic [31:0] ed;
      logic [3:0] ebe;
      n  = q.size();
      hz = 1'b0;
      foreach (q[i]) if (q[i].wa == Ld_Addr[AW+1:2]) hz = 1'b1;
      hz      = hz && Ld_Req;
      m_drain = (n > 0) && (!Ld_Req || hz);
      m_acc   = St_Valid && (n < DEPTH);
      a  = int'(St_Addr[1:0]);
      nb = (St_Size == 2'd3) ? 0 : (1 << St_Size);
      m_bad = (nb == 0) || ((a % nb) != 0);
      if (nb == 0) nb = 1;
      m_new.wa = St_Addr[AW+1:2];
      m_new.be = 4'(((1 << nb) - 1) << a);
      for (int i = 0; i < 4; i++) m_new.d[8*i +: 8] = St_Data[8*(i % nb) +: 8];
      m_push = m_acc && !m_bad;
      if (m_drain) begin
         ea = q[0].wa; ed = q[0].d; ebe = q[0].be;
      end else begin
         ea = Ld_Addr[AW+1:2]; ed = 32'h0; ebe = 4'h0;
      end
      chk("count",  Count,     n);
      chk("empty",  Empty,     n == 0);
      chk("ready",  St_Ready,  n < DEPTH);
      chk("hazard", Ld_Hazard, hz);
      chk("we",     Mem_WE,    m_drain);
      chk("addr",   Mem_A,     ea);
      chk("din",    Mem_Din,   ed);
      chk("be",     Mem_BE,    ebe);
      chk("st_err", St_Err,    exp_err);
   endtask

   task automatic advance();
      @(posedge Clk);
      if (m_drain) void'(q.pop_front());
      if (m_push) q.push_back(m_new);
      exp_err = m_acc && m_bad;
   endtask

   task automatic step(input logic v, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] sz, input logic lr, input logic [31:0] la);
      drive(v, sa, sd, sz, lr, la);
      model_check();
      advance();
   endtask

   initial begin
      logic [31:0] sa, la;
      Rst_n = 1'b0; St_Valid = 0; St_Addr = 0; St_Data = 0; St_Size = 0; Ld_Req = 0; Ld_Addr = 0;
      exp_err = 1'b0;
      #3;
      chk("rst_count", Count, 0);
      chk("rst_empty", Empty, 1);
      chk("rst_ready", St_Ready, 1);
      chk("rst_we", Mem_WE, 0);
      chk("rst_err", St_Err, 0);
      @(negedge Clk); Rst_n = 1'b1;

      // Asynchronous reset while draining
      for (int i = 0; i < 3; i++) step(1, 32'h40 + 4*i, $urandom, 2'd2, 1, 32'h800);
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      #2 Rst_n = 1'b0;
      #1;
      chk("t1_count", Count, 0);
      chk("t1_we", Mem_WE, 0);
      chk("t1_empty", Empty, 1);
      q.delete();
      exp_err = 1'b0;
      @(negedge Clk); Rst_n = 1'b1;

      // Byte store at offset 3
      step(1, 32'h103, 32'hAB, 2'd0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      chk("t2_a", Mem_A, 11'h040);
      chk("t2_be", Mem_BE, 4'b1000);
      chk("t2_din", Mem_Din, 32'hABABABAB);
      chk("t2_we", Mem_WE, 1);
      advance();

      // Upper halfword, then a misaligned word
      step(1, 32'h2, 32'h1234, 2'd1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      chk("t3_be", Mem_BE, 4'b1100);
      chk("t3_din", Mem_Din, 32'h12341234);
      advance();
      step(1, 32'h6, 32'hDEADBEEF, 2'd2, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      chk("t3_err", St_Err, 1);
      chk("t3_cnt", Count, 0);
      advance();
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      chk("t3_err_clr", St_Err, 0);
      advance();

      // Fill while the load owns the port, then drain in order
      for (int i = 0; i < 4; i++) step(1, 32'h20 + 4*i, 32'h1000 + i, 2'd2, 1, 32'h800);
      drive(1, 32'h30, 32'h5555, 2'd2, 1, 32'h800);
      model_check();
      chk("t4_ready", St_Ready, 0);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         model_check();
         chk("t4_order", Mem_Din, 32'h1000 + i);
         advance();
      end

      // Load hits a queued store
      step(1, 32'h10, 32'hCAFEF00D, 2'd2, 0, 0);
      drive(0, 0, 0, 0, 1, 32'h12);
      model_check();
      chk("t5_hz", Ld_Hazard, 1);
      chk("t5_we", Mem_WE, 1);
      chk("t5_a", Mem_A, 4);
      advance();
      drive(0, 0, 0, 0, 1, 32'h12);
      model_check();
      chk("t5_hz_clr", Ld_Hazard, 0);
      chk("t5_a_ld", Mem_A, 4);
      chk("t5_we_off", Mem_WE, 0);
      advance();

      // Near-full enqueue+pop streaming across pointer wrap
      for (int i = 0; i < DEPTH-1; i++) step(1, 32'h100 + 4*i, $urandom, 2'd2, 1, 32'h800);
      for (int i = 0; i < 2*DEPTH; i++) begin
         drive(1, 32'h200 + 4*i, $urandom, 2'd2, 0, 0);
         model_check();
         chk("t6_cnt", Count, DEPTH-1);
         advance();
      end
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0);

      // Random traffic with deliberately overlapping load/store addresses
      for (int i = 0; i < 600; i++) begin
         sa = 32'($urandom_range(0, 47));
         la = 32'($urandom_range(0, 47));
         step(1'($urandom_range(0, 1)), sa, $urandom, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 6), la);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
